// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_ctrl
//  Description : LSU-facing data memory with byte-masked writes, word reads,
//                programmable wait states and a core stall handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_ctrl #(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid,
    input  logic        cs,
    input  logic        wr,
    input  logic [3:0]  mask,
    input  logic [31:0] addr,
    input  logic [31:0] data_wr,
    output logic [31:0] data_rd,
    output logic        rvalid,
    output logic        stall,
    output logic        err
);
    localparam int c_idx_w = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [3:0]         r_cnt;
    logic [31:0]        r_addr;
    logic               r_wr;
    logic [3:0]         r_mask;
    logic [31:0]        r_data_wr;
    logic [31:0]        r_data_rd;
    logic               r_err;
    logic [31:0]        r_mem [DEPTH_WORDS];

    logic               w_req;
    logic               w_commit;
    logic [31:0]        w_offset;
    logic               w_in_range;
    logic [c_idx_w-1:0] w_idx;

    assign w_req      = valid && !cs;
    assign w_commit   = (r_state == ST_BUSY) && (r_cnt == 4'd0);
    assign w_offset   = r_addr - BASE_ADDR;
    // Both bounds matter: below-base addresses wrap to huge offsets.
    assign w_in_range = (r_addr >= BASE_ADDR) && ((w_offset >> 2) < 32'(DEPTH_WORDS));
    assign w_idx      = w_offset[c_idx_w+1:2];

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req)    w_state_next = ST_BUSY;
            ST_BUSY: if (w_commit) w_state_next = ST_DONE;
            ST_DONE:               w_state_next = ST_IDLE;
            default:               w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= 4'd0;
            r_err     <= 1'b0;
            r_addr    <= 32'd0;
            r_wr      <= 1'b0;
            r_mask    <= 4'd0;
            r_data_wr <= 32'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_err <= 1'b0;
                    if (w_req) begin
                        r_addr    <= addr;
                        r_wr      <= wr;
                        r_mask    <= mask;
                        r_data_wr <= data_wr;
                        r_cnt     <= 4'(WAIT_CYCLES);
                    end
                end
                ST_BUSY: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                    else               r_err <= !w_in_range;
                end
                default: ;
            endcase
        end
    end

    // Reset gates the commit so a write on the reset edge is dropped.
    always_ff @(posedge clk) begin
        if (!rst && w_commit && !r_wr && w_in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (r_mask[i]) r_mem[w_idx][8*i +: 8] <= r_data_wr[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_rd <= 32'd0;
        end else if (w_commit && r_wr) begin
            r_data_rd <= w_in_range ? r_mem[w_idx] : 32'd0;
        end
    end

    assign data_rd = r_data_rd;
    assign err     = r_err;
    assign rvalid  = (r_state == ST_DONE);
    assign stall   = (r_state == ST_BUSY) || ((r_state == ST_IDLE) && w_req);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_ctrl
//  Description : Randomized self-checking bench for data_mem_ctrl against a
//                word-array reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_ctrl;
    localparam int          WAIT  = 1;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam int          NW    = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        cs;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        rvalid;
    logic        stall;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] model_mem [NW];
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_CYCLES(WAIT),
        .BASE_ADDR  (BASE)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .cs     (cs),
        .wr     (wr),
        .mask   (mask),
        .addr   (addr),
        .data_wr(data_wr),
        .data_rd(data_rd),
        .rvalid (rvalid),
        .stall  (stall),
        .err    (err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (((a - BASE) / 4) < DEPTH);
    endfunction

    // One full access; inputs change randomly during BUSY to prove they are ignored.
    task automatic access(input bit is_rd, input logic [3:0] m, input logic [31:0] a,
                          input logic [31:0] d, output logic [31:0] rd_o, output logic err_o);
        int cyc;
        int nst;
        @(negedge clk);
        valid = 1'b1; cs = 1'b0; wr = is_rd; mask = m; addr = a; data_wr = d;
        #1;
        cyc = 0; nst = 0;
        while (!rvalid && cyc < 40) begin
            if (stall) nst++;
            @(negedge clk);
            cyc++;
            wr = 1'($urandom); mask = 4'($urandom); addr = $urandom; data_wr = $urandom;
        end
        check("latency", 32'(cyc), 32'(WAIT + 2));
        check("stall_cycles", 32'(nst), 32'(WAIT + 2));
        check("stall_in_done", 32'(stall), 32'd0);
        rd_o  = data_rd;
        err_o = err;
        valid = 1'b0; cs = 1'b1;
    endtask

    // Run an access and compare it with the reference model.
    task automatic do_op(input bit is_rd, input logic [3:0] m, input logic [31:0] a,
                         input logic [31:0] d);
        logic [31:0] rd;
        logic        e;
        logic [31:0] exp_rd;
        int          w;
        bit          ok;
        ok = in_range(a);
        w  = int'((a - BASE) >> 2);
        access(is_rd, m, a, d, rd, e);
        check("err", 32'(e), 32'(!ok));
        if (is_rd) begin
            exp_rd  = (ok && w < NW) ? model_mem[w] : 32'd0;
            if (!ok || w < NW) check("read_data", rd, exp_rd);
            last_rd = rd;
        end else begin
            check("wr_keeps_rd", rd, last_rd);
            if (ok && w < NW) begin
                for (int i = 0; i < 4; i++)
                    if (m[i]) model_mem[w][8*i +: 8] = d[8*i +: 8];
            end
        end
    endtask

    initial begin
        logic [31:0] a;
        int          nrv;
        int          nst;
        rst = 1'b1; valid = 1'b0; cs = 1'b1; wr = 1'b0; mask = 4'd0; addr = 32'd0; data_wr = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_stall", 32'(stall), 32'd0);
        check("reset_rvalid", 32'(rvalid), 32'd0);
        check("reset_data_rd", data_rd, 32'd0);
        check("reset_err", 32'(err), 32'd0);
        rst = 1'b0;
        last_rd = 32'd0;

        for (int i = 0; i < NW; i++) begin
            model_mem[i] = $urandom;
            do_op(1'b0, 4'hF, BASE + 32'(i * 4), model_mem[i]);
        end

        do_op(1'b0, 4'hF, 32'h10, 32'hDEAD_BEEF);
        do_op(1'b1, 4'h0, 32'h10, 32'h0);
        check("plan_deadbeef", last_rd, 32'hDEAD_BEEF);

        do_op(1'b0, 4'hF, 32'h20, 32'h1122_3344);
        do_op(1'b0, 4'b0100, 32'h20, 32'h00AA_0000);
        do_op(1'b1, 4'h0, 32'h20, 32'h0);
        check("plan_byte_lane", last_rd, 32'h11AA_3344);
        do_op(1'b0, 4'b0000, 32'h20, 32'hFFFF_FFFF);
        do_op(1'b1, 4'h0, 32'h22, 32'h0);
        check("plan_mask_zero", last_rd, 32'h11AA_3344);

        do_op(1'b1, 4'h0, 32'h1000, 32'h0);
        do_op(1'b0, 4'hF, 32'h1000, 32'hCAFE_F00D);
        do_op(1'b0, 4'hF, 32'h1010, 32'hCAFE_F00D);
        do_op(1'b1, 4'h0, 32'h0, 32'h0);
        do_op(1'b1, 4'h0, 32'h10, 32'h0);

        // Reset during BUSY with counter still nonzero.
        @(negedge clk);
        valid = 1'b1; cs = 1'b0; wr = 1'b0; mask = 4'hF; addr = 32'h30; data_wr = 32'h55;
        @(negedge clk);
        rst = 1'b1; valid = 1'b0; cs = 1'b1;
        @(negedge clk);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b0;
        last_rd = 32'd0;
        // Reset on the commit edge itself.
        @(negedge clk);
        valid = 1'b1; cs = 1'b0; wr = 1'b0; mask = 4'hF; addr = 32'h34; data_wr = 32'h77;
        repeat (WAIT + 1) @(negedge clk);
        rst = 1'b1; valid = 1'b0; cs = 1'b1;
        @(negedge clk);
        check("rst_commit_rvalid", 32'(rvalid), 32'd0);
        rst = 1'b0;
        last_rd = 32'd0;
        do_op(1'b1, 4'h0, 32'h30, 32'h0);
        do_op(1'b1, 4'h0, 32'h34, 32'h0);

        // Chip select high: no access.
        @(negedge clk);
        valid = 1'b1; cs = 1'b1; wr = 1'b0; mask = 4'hF; addr = 32'h40; data_wr = 32'h0;
        nrv = 0; nst = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (rvalid) nrv++;
            if (stall) nst++;
            @(negedge clk);
        end
        check("cs_high_rvalid", 32'(nrv), 32'd0);
        check("cs_high_stall", 32'(nst), 32'd0);
        valid = 1'b0;

        // Request held continuously: one access per WAIT+3 cycles.
        @(negedge clk);
        valid = 1'b1; cs = 1'b0; wr = 1'b1; mask = 4'h0; addr = 32'h10; data_wr = 32'h0;
        nrv = 0; nst = 0;
        for (int i = 0; i < 3 * (WAIT + 3); i++) begin
            #1;
            if (rvalid) nrv++;
            if (stall) nst++;
            @(negedge clk);
        end
        check("held_rvalid_pulses", 32'(nrv), 32'd3);
        check("held_stall_cycles", 32'(nst), 32'(3 * (WAIT + 2)));
        check("held_restart_stall", 32'(stall), 32'd1);
        check("held_read_data", data_rd, model_mem[4]);
        repeat (WAIT + 2) @(negedge clk);
        valid = 1'b0; cs = 1'b1;
        last_rd = data_rd;

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 4))
                0:       a = 32'h1000 + 32'($urandom_range(0, NW - 1) * 4) + 32'($urandom_range(0, 3));
                1:       a = 32'h1000 | $urandom;
                default: a = BASE + 32'($urandom_range(0, NW * 4 - 1));
            endcase
            do_op(1'($urandom), 4'($urandom), a, $urandom);
        end
        for (int i = 0; i < NW; i++) do_op(1'b1, 4'h0, BASE + 32'(i * 4), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
